// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: handshake/status bundle for param_sync_fifo.
//   master : producer/consumer side, which drives flush, wr_en, din and rd_en.
//   slave  : FIFO side, which drives dout, the flags, count and the error pulses.
// The parameters must match those of the attached param_sync_fifo.
interface param_sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with exact status flags, programmable
// almost-full and almost-empty thresholds, an occupancy count, overflow and
// underflow error pulses, and a synchronous flush.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   fifo  param_sync_fifo_if.slave, which carries:
//         flush, wr_en, din, rd_en                            (in)
//         dout, full, empty, almost_full, almost_empty,
//         count, overflow, underflow                          (out)
//
// Build option: PARAM_SYNC_FIFO_FWFT_EN selects first-word-fall-through.
//   In that mode dout shows mem[rd_ptr] while the FIFO is not empty and 0
//   while it is empty, and rd_en acknowledges (pops) the displayed word.
//   Without it, dout is a register that loads on each accepted read.
module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic            clk,
  input  logic            rst,
  param_sync_fifo_if.slave fifo
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  AE_C   = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0]  CNT_1  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_1  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf_q, unf_q;
  logic              full_w, empty_w;
  logic              rd_ok, wr_ok;

  // The flags decode the registered count directly, so they are exact in the
  // cycle after each accepted operation.
  assign full_w  = (count == FULL_C);
  assign empty_w = (count == '0);

  // A write into a full FIFO is allowed when a read is requested in the same
  // cycle. A full FIFO is never empty, so that read is always accepted.
  assign rd_ok = fifo.rd_en && !empty_w;
  assign wr_ok = fifo.wr_en && (!full_w || fifo.rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (fifo.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_1;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_1;
        2'b01:   count <= count - CNT_1;
        default: count <= count;
      endcase
      ovf_q <= fifo.wr_en && !wr_ok;
      unf_q <= fifo.rd_en && !rd_ok;
    end
  end

  // Storage is not reset. During a flush its contents are don't-care, so the
  // write is gated off to keep the array quiet.
  always_ff @(posedge clk) begin
    if (wr_ok && !fifo.flush) mem[wr_ptr] <= fifo.din;
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // The head word is visible without a read. Zero is driven while empty so
  // that stale array contents do not leak out.
  assign fifo.dout = empty_w ? '0 : mem[rd_ptr];
`else
  logic [DATA_W-1:0] dout_q;

  // On a read of a full FIFO with a simultaneous write, rd_ptr equals wr_ptr.
  // This register samples the old word, because the array write lands at the
  // same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          dout_q <= '0;
    else if (rd_ok && !fifo.flush)    dout_q <= mem[rd_ptr];
  end

  assign fifo.dout = dout_q;
`endif

  assign fifo.full         = full_w;
  assign fifo.empty        = empty_w;
  assign fifo.almost_full  = (count >= AF_C);
  assign fifo.almost_empty = (count <= AE_C);
  assign fifo.count        = count;
  assign fifo.overflow     = ovf_q;
  assign fifo.underflow    = unf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed and randomized checks of param_sync_fifo.
// The reference model is a queue of words plus registered error/dout state.
module tb_param_sync_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = DEPTH - 2;
  localparam int AE     = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef logic [CW+5:0] stat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  param_sync_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fifo(bus)
  );

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_ov = 1'b0, m_un = 1'b0;
  int total = 0, bad = 0;

  function automatic stat_t exp_stat();
    int n = q.size();
    return {CW'(n), n == DEPTH, n == 0, n >= AF, n <= AE, m_ov, m_un};
  endfunction

  function automatic stat_t obs_stat();
    return {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
            bus.overflow, bus.underflow};
  endfunction

  function automatic logic [DATA_W-1:0] exp_dout();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ov   = 1'b0;
    m_un   = 1'b0;
  endtask

  // Applies one cycle of stimulus, advances the model at the edge, and
  // returns 1 ns after the edge so that outputs can be sampled.
  task automatic drive(input logic wr, input logic [DATA_W-1:0] d,
                       input logic rd, input logic fl);
    logic rd_ok, wr_ok;
    bus.wr_en = wr; bus.din = d; bus.rd_en = rd; bus.flush = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      rd_ok = rd && (q.size() != 0);
      wr_ok = wr && ((q.size() != DEPTH) || rd);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      m_ov = wr && !wr_ok;
      m_un = rd && !rd_ok;
    end
    #1;
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.rd_en = 0; bus.flush = 0; bus.din = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs_stat() !== stat_t'({CW'(0), 6'b010100}))
      begin bad++; $display("FAIL reset_status got=%h want=%h", obs_stat(), {CW'(0), 6'b010100}); end
    total++;
    if (bus.dout !== '0) begin bad++; $display("FAIL reset_dout got=%h want=0", bus.dout); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
      total++;
      if (obs_stat() !== exp_stat())
        begin bad++; $display("FAIL fill_status[%0d] got=%h want=%h", i, obs_stat(), exp_stat()); end
    end
    total++;
    if (!(bus.full === 1'b1 && bus.count === CW'(DEPTH)))
      begin bad++; $display("FAIL fill_full got full=%b count=%0d want full=1 count=%0d", bus.full, bus.count, DEPTH); end
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    total++;
    if (bus.overflow !== 1'b1 || obs_stat() !== exp_stat())
      begin bad++; $display("FAIL overflow got=%h want=%h", obs_stat(), exp_stat()); end
    drive(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (obs_stat() !== exp_stat())
      begin bad++; $display("FAIL overflow_clear got=%h want=%h", obs_stat(), exp_stat()); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (obs_stat() !== exp_stat() || bus.dout !== exp_dout())
        begin bad++; $display("FAIL drain[%0d] got=%h/%h want=%h/%h", i, obs_stat(), bus.dout, exp_stat(), exp_dout()); end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (bus.underflow !== 1'b1 || obs_stat() !== exp_stat() || bus.dout !== exp_dout())
      begin bad++; $display("FAIL underflow got=%h/%h want=%h/%h", obs_stat(), bus.dout, exp_stat(), exp_dout()); end
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    total++;
    if (bus.dout !== 8'h0F) begin bad++; $display("FAIL underflow_hold got=%h want=0f", bus.dout); end
`endif
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, DATA_W'(8'h40 + i), 1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    total++;
    if (bus.overflow !== 1'b0 || bus.count !== CW'(DEPTH) || obs_stat() !== exp_stat())
      begin bad++; $display("FAIL full_simul got=%h want=%h", obs_stat(), exp_stat()); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (obs_stat() !== exp_stat() || bus.dout !== exp_dout())
        begin bad++; $display("FAIL full_simul_rd[%0d] got=%h/%h want=%h/%h", i, obs_stat(), bus.dout, exp_stat(), exp_dout()); end
    end
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    total++;
    if (bus.dout !== 8'hAA) begin bad++; $display("FAIL wrap_word got=%h want=aa", bus.dout); end
`endif
  endtask

  task automatic test_empty_simul();
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    total++;
    if (bus.underflow !== 1'b1 || bus.count !== CW'(1) || obs_stat() !== exp_stat())
      begin bad++; $display("FAIL empty_simul got=%h want=%h", obs_stat(), exp_stat()); end
    drive(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (obs_stat() !== exp_stat() || bus.dout !== exp_dout())
      begin bad++; $display("FAIL empty_simul_rd got=%h/%h want=%h/%h", obs_stat(), bus.dout, exp_stat(), exp_dout()); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive(1'b1, DATA_W'(8'h90 + i), 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    total++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b0 || obs_stat() !== exp_stat() || bus.dout !== exp_dout())
      begin bad++; $display("FAIL flush got=%h/%h want=%h/%h", obs_stat(), bus.dout, exp_stat(), exp_dout()); end
    drive(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (obs_stat() !== exp_stat())
      begin bad++; $display("FAIL flush_idle got=%h want=%h", obs_stat(), exp_stat()); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, DATA_W'(8'hC0 + i), (i == 3), 1'b0);
    bus.wr_en = 1'b1; bus.rd_en = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    total++;
    if (obs_stat() !== exp_stat() || bus.dout !== '0)
      begin bad++; $display("FAIL async_reset got=%h/%h want=%h/0", obs_stat(), bus.dout, exp_stat()); end
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), DATA_W'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      total++;
      if (obs_stat() !== exp_stat() || bus.dout !== exp_dout())
        begin bad++; $display("FAIL random[%0d] got=%h/%h want=%h/%h", i, obs_stat(), bus.dout, exp_stat(), exp_dout()); end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    total++;
    if (bus.dout !== 8'h3C) begin bad++; $display("FAIL fwft_show got=%h want=3c", bus.dout); end
    drive(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (bus.dout !== 8'h00 || bus.empty !== 1'b1)
      begin bad++; $display("FAIL fwft_pop got dout=%h empty=%b want dout=00 empty=1", bus.dout, bus.empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_full_simul();
    test_empty_simul();
    test_flush();
    test_async_reset();
    test_random();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
